// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the memory-port arbiter.
// FSM encoding is one-hot so each state test reduces to a single flop bit.
package mem_arb_pkg;

    // One-hot arbiter states.
    localparam logic [2:0] ST_IDLE    = 3'b001;
    localparam logic [2:0] ST_GRANT   = 3'b010;
    localparam logic [2:0] ST_RELEASE = 3'b100;

    // Requester identities: port 0 is the I-cache, port 1 the D-cache.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Default cap on beats a locked owner may hold while the other waits.
    localparam int MAX_BURST_DEFAULT = 8;

    // Width of a counter that must hold 0..max_burst inclusive.
    function automatic int beat_cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: two-way round-robin pick, purely combinational.
// With both requests active the port that did not own last wins; a lone
// request always wins. winner holds last_owner when nothing is requested.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant,
    output logic winner
);

    // Select the winner from the request pair and the previous owner.
    always_comb begin
        grant  = req0 | req1;
        winner = last_owner;
        if (req0 && req1) begin
            winner = ~last_owner;
        end else if (req0) begin
            winner = OWNER_I;
        end else if (req1) begin
            winner = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between the I-cache (port 0)
// and D-cache (port 1) refill/write-back paths. Round-robin arbitration with
// a lock that keeps the grant across a cache-line burst, capped at MAX_BURST
// beats while the other port is waiting. Every grant ends with a one-cycle
// RELEASE bubble so beats never run back to back across owners.
// Optional build macro ARB_PERF_COUNTERS_EN adds grant/contention counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                r0_valid,
    input  logic                r1_valid,
    input  logic                r0_lock,
    input  logic                r1_lock,
    input  logic [ADDR_W-1:0]   r0_addr,
    input  logic [ADDR_W-1:0]   r1_addr,
    input  logic [DATA_W-1:0]   r0_wdata,
    input  logic [DATA_W-1:0]   r1_wdata,
    input  logic [DATA_W/8-1:0] r0_wstrb,
    input  logic [DATA_W/8-1:0] r1_wstrb,
    output logic                r0_ready,
    output logic                r1_ready,
    output logic [DATA_W-1:0]   r0_rdata,
    output logic [DATA_W-1:0]   r1_rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                owner,
    output logic                busy
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]         grants0,
    output logic [31:0]         grants1,
    output logic [31:0]         contention
`endif
);

    localparam int              CNT_W   = beat_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(MAX_BURST);

    logic [2:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             arb_grant;
    logic             arb_winner;
    logic             in_grant;
    logic             own_valid;
    logic             own_lock;
    logic             oth_valid;
    logic             beat;
    logic             forced_rel;
    logic [CNT_W:0]   cnt_inc;

    rr_pick u_rr_pick (
        .req0       (r0_valid),
        .req1       (r1_valid),
        .last_owner (owner_q),
        .grant      (arb_grant),
        .winner     (arb_winner)
    );

    // Owner-relative view of the requesters and the beat / forced-release events.
    always_comb begin
        in_grant   = (state_q == ST_GRANT);
        own_valid  = owner_q ? r1_valid : r0_valid;
        own_lock   = owner_q ? r1_lock  : r0_lock;
        oth_valid  = owner_q ? r0_valid : r1_valid;
        beat       = in_grant && own_valid && m_ready;
        cnt_inc    = {1'b0, beat_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        // Lock is sampled on the beat itself, so a lock rising with m_ready counts.
        forced_rel = beat && own_lock && oth_valid && (cnt_inc >= MAX_EXT);
    end

    // Next-state logic for the IDLE / GRANT / RELEASE sequence.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_grant) begin
                    state_d    = ST_GRANT;
                    owner_d    = arb_winner;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (beat) begin
                    // Saturate rather than wrap so a long uncontended locked
                    // burst still triggers a release once the other port asks.
                    if (beat_cnt_q != MAX_CNT) begin
                        beat_cnt_d = cnt_inc[CNT_W-1:0];
                    end
                    if (!own_lock || forced_rel) begin
                        state_d = ST_RELEASE;
                    end
                end else if (!own_valid && !own_lock) begin
                    // Owner withdrew before completion: give up the port, no beat.
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves owner=1 so port 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_D;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Downstream request path: owner's signals only while granted.
    always_comb begin
        m_valid = in_grant && own_valid;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        if (in_grant) begin
            m_addr  = owner_q ? r1_addr  : r0_addr;
            m_wdata = owner_q ? r1_wdata : r0_wdata;
            m_wstrb = owner_q ? r1_wstrb : r0_wstrb;
        end
    end

    // Return path: ready steered to the owner, read data fanned out to both.
    always_comb begin
        r0_ready = beat && (owner_q == OWNER_I);
        r1_ready = beat && (owner_q == OWNER_D);
        r0_rdata = reset ? '0 : m_rdata;
        r1_rdata = reset ? '0 : m_rdata;
        owner    = owner_q;
        busy     = in_grant;
    end

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] grants0_q, grants0_d;
    logic [31:0] grants1_q, grants1_d;
    logic [31:0] contention_q, contention_d;
    logic        arb_conflict;

    // Count grants per port and contention events (IDLE conflicts, forced releases).
    always_comb begin
        arb_conflict = (state_q == ST_IDLE) && r0_valid && r1_valid;
        grants0_d    = grants0_q;
        grants1_d    = grants1_q;
        contention_d = contention_q;
        if ((state_q == ST_IDLE) && arb_grant) begin
            if (arb_winner == OWNER_I) begin
                grants0_d = grants0_q + 32'd1;
            end else begin
                grants1_d = grants1_q + 32'd1;
            end
        end
        if (arb_conflict || forced_rel) begin
            contention_d = contention_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset and wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grants0_q    <= '0;
            grants1_q    <= '0;
            contention_q <= '0;
        end else begin
            grants0_q    <= grants0_d;
            grants1_q    <= grants1_d;
            contention_q <= contention_d;
        end
    end

    assign grants0    = grants0_q;
    assign grants1    = grants1_q;
    assign contention = contention_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port (`mem_prin` valid/ready interface) between two cache-side requesters: port 0 is the instruction-cache refill path, port 1 is the data-cache refill/write-back path.
- Arbitration is round-robin.
- A lock lets one requester keep the grant for a whole cache-line burst (write-back followed by refill) without interleaving.
- Sits between the cache controllers and `mem_prin`.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_BURST, 8, maximum beats one locked owner may hold while the other port waits; power of two, range 2..256.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- r0_valid, r1_valid  in  1  request valid, held until ready.
- r0_lock, r1_lock  in  1  keep grant after current beat.
- r0_addr, r1_addr  in  ADDR_W  word address.
- r0_wdata, r1_wdata  in  DATA_W  write data.
- r0_wstrb, r1_wstrb  in  DATA_W/8  byte strobes; 0 means read.
- r0_ready, r1_ready  out  1  beat-complete pulse.
- r0_rdata, r1_rdata  out  DATA_W  read data, valid with ready.
- m_valid  out  1  downstream request.
- m_addr  out  ADDR_W  downstream address.
- m_wdata  out  DATA_W  downstream write data.
- m_wstrb  out  DATA_W/8  downstream strobes.
- m_ready  in  1  downstream beat-complete pulse.
- m_rdata  in  DATA_W  downstream read data.
- owner  out  1  current or last grant holder.
- busy  out  1  a grant is active.

Interface rule (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values while `reset`=1:
  - state=IDLE, owner=1 (so port 0 wins the first contention), busy=0, beat_cnt=0.
  - m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0.
  - r0_ready=r1_ready=0, rdata=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Neither port valid: stay in IDLE.
  - One port valid: grant it.
  - Both valid: grant !owner (round robin).
  - On grant: owner<=winner, busy<=1, beat_cnt<=0, go to GRANT. One cycle arbitration latency; m_valid rises the cycle after the request is seen.
- GRANT:
  - m_valid/m_addr/m_wdata/m_wstrb are combinationally muxed from the owner's inputs.
  - m_valid = owner's valid.
  - m_ready goes to the owner's ready only; the non-owner's ready stays 0.
  - m_rdata is registered-free and passed to both rdata ports.
- GRANT exit on a beat (m_ready=1):
  - beat_cnt++, saturating at MAX_BURST.
  - Owner lock=0: go to RELEASE.
  - Owner lock=1 and (other port idle, or beat_cnt+1 < MAX_BURST): stay in GRANT.
  - Owner lock=1, other port valid, and beat_cnt+1 == MAX_BURST: forced release to RELEASE.
- GRANT abort: owner drops valid with m_ready=0 and lock=0 → go to RELEASE with no beat counted. Owner valid=0 with lock=1 keeps the grant (burst gap allowed).
- RELEASE:
  - One bubble cycle with busy=0 and m_valid=0.
  - Gives the requester time to drop valid after ready; then go to IDLE.
  - No back-to-back beats across owners.
- Simultaneous events:
  - A request arriving in RELEASE is arbitrated in the following IDLE cycle.
  - Lock rising on the same cycle as m_ready counts for that beat.
- Reset mid-burst: everything returns to reset values immediately. The downstream transaction is abandoned; `mem_prin` sees m_valid=0.
- beat_cnt width is $clog2(MAX_BURST)+1 and never wraps.

Optional Feature:
- Macro: ARB_PERF_COUNTERS_EN.
- Enabled:
  - Adds outputs grants0, grants1, contention (32 bits each).
  - grantsN increments on each IDLE→GRANT to port N.
  - contention increments on each IDLE cycle with both ports valid, and on each forced release.
  - All counters clear on reset and wrap modulo 2^32.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (one-hot IDLE=1, GRANT=2, RELEASE=4);
  - OWNER_I=0, OWNER_D=1;
  - the default MAX_BURST.
- Natural sub-module: rr_pick. It is purely combinational and takes (req0, req1, last_owner) → (grant, winner). Reusable if ports are added.

Test Plan:
- Port 0 only: reads addr 0x100; m_ready after 8 cycles with m_rdata=0xDEADBEEF → r0_ready pulse carries 0xDEADBEEF, r1_ready=0, then RELEASE then IDLE.
- Both ports valid in the same cycle after reset → port 0 is granted first. Port 1 is granted after port 0's beat plus the RELEASE bubble. Next contention → port 0 again (alternation).
- Port 1 locked write-back of 2 words (wstrb=0xF) then 2-word refill, lock dropped on the last beat, with port 0 continuously valid → all 4 beats go to port 1 with no port 0 interleave; port 0 is granted afterwards.
- MAX_BURST=4, port 0 locked indefinitely, port 1 valid → forced release after beat 4, port 1 granted next. With ARB_PERF_COUNTERS_EN, contention=2 (1 arbitration conflict + 1 forced release).
- Reset asserted while GRANT with m_valid=1 → same cycle m_valid=0 and busy=0; after release, port 1 request is granted per reset owner rule.
- Owner drops valid before m_ready, lock=0 → RELEASE, no ready pulse, beat_cnt unchanged.
